brent_kung_sub_pipe: RTL and testbench

//  Pipelined N-bit subtractor, D = A - B - Bin, built on a Brent-Kung parallel-prefix carry network.

---
 rtl/brent_kung_sub_pipe.sv | 134 +++++++++++++
 tb/tb_brent_kung_sub_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/brent_kung_sub_pipe.sv
// Two-stage pipelined subtractor D = A - B - Bin (A + ~B + ~Bin) with a Brent-Kung carry network.
// Both valid bits form the only control state; stalls propagate backward combinationally.
module brent_kung_sub_pipe #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         zero,
    output logic         neg
);
    localparam int L = $clog2(N);

    if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("brent_kung_sub_pipe: N must be a power of two >= 4");
    end

    logic         adv1, adv2;
    logic         s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [N-1:0] p_q, p_d, g_q, g_d;
    logic         cin_q, cin_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic [N-1:0] diff_q, diff_d;
    logic         bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
    logic [N-1:0] gg, pp;
    logic [N:0]   c;

    // Carry-in is folded into bit 0 so the prefix G at bit i is the carry into bit i+1.
    always_comb begin
        pp    = p_q;
        gg    = g_q;
        gg[0] = g_q[0] | (p_q[0] & cin_q);
        for (int l = 0; l < L; l++) begin
            for (int i = 0; i < N; i++) begin
                if ((i + 1) % (2 << l) == 0) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end
        for (int l = L - 2; l >= 0; l--) begin
            for (int i = 0; i < N; i++) begin
                if (i >= (2 << l) && (i + 1) % (2 << l) == (1 << l)) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                end
            end
        end
        c = {gg, cin_q};
    end

    always_comb begin
        adv2       = !s2_valid_q || out_ready;
        adv1       = !s1_valid_q || adv2;
        s1_valid_d = s1_valid_q;
        p_d        = p_q;
        g_d        = g_q;
        cin_d      = cin_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            // Data regs only move with a real op so idle outputs keep their last value.
            if (in_valid) begin
                p_d     = a ^ ~b;
                g_d     = a & ~b;
                cin_d   = ~bin;
                a_msb_d = a[N-1];
                b_msb_d = b[N-1];
            end
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d = p_q ^ c[N-1:0];
                bout_d = ~c[N];
                ovf_d  = (a_msb_q != b_msb_q) && (diff_d[N-1] != a_msb_q);
                zero_d = (diff_d == '0);
                neg_d  = diff_d[N-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            cin_q      <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            p_q        <= p_d;
            g_q        <= g_d;
            cin_q      <= cin_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
endmodule

// File: tb/tb_brent_kung_sub_pipe.sv
// Self-checking bench for brent_kung_sub_pipe (N=8): directed vectors, streaming,
// back-pressure, mid-flight reset and a randomized scoreboard run.
module tb_brent_kung_sub_pipe;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready, bin;
    logic [N-1:0] a, b;
    logic         in_ready, out_valid, bout, ovf, zero, neg;
    logic [N-1:0] diff;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N+3:0] exp_q[$];

    always #5 clk = ~clk;

    brent_kung_sub_pipe #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    // Reference: plain integer subtraction, flags from their arithmetic definitions.
    function automatic logic [N+3:0] model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                           input logic bi);
        int d;
        logic [N-1:0] dm;
        d  = int'(av) - int'(bv) - int'(bi);
        dm = d[N-1:0];
        return {dm, (int'(av) < int'(bv) + int'(bi)), (av[N-1] != bv[N-1]) && (dm[N-1] != av[N-1]),
                (dm == 0), dm[N-1]};
    endfunction

    task automatic test_reset();
        n_tests++;
        if ({out_valid, diff, bout, ovf, zero, neg, in_ready} !== {1'b0, {N{1'b0}}, 4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state got %b exp %b", {out_valid, diff, bout, ovf, zero, neg, in_ready},
                     {1'b0, {N{1'b0}}, 4'b0000, 1'b1});
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
    endtask

    task automatic test_directed();
        logic [N-1:0] va[6]  = '{8'h05, 8'h00, 8'h80, 8'h10, 8'h00, 8'h7F};
        logic [N-1:0] vb[6]  = '{8'h03, 8'h01, 8'h01, 8'h0F, 8'hFF, 8'h80};
        logic         vbi[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [N+3:0] ve[6]  = '{{8'h02, 4'b0000}, {8'hFF, 4'b1001}, {8'h7F, 4'b0100},
                                 {8'h00, 4'b0010}, {8'h00, 4'b1010}, {8'hFF, 4'b1101}};
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a = va[k]; b = vb[k]; bin = vbi[k]; in_valid = 1'b1;
            @(posedge clk) #1 in_valid = 1'b0;
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL latency_early[%0d] got out_valid=%b exp 0", k, out_valid);
            end
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL latency[%0d] got out_valid=%b exp 1", k, out_valid);
            end
            n_tests++;
            if ({diff, bout, ovf, zero, neg} !== ve[k]) begin
                n_fail++;
                $display("FAIL directed[%0d] got %h exp %h", k, {diff, bout, ovf, zero, neg}, ve[k]);
            end
            @(posedge clk) #1;
        end
    endtask

    task automatic test_stream();
        int got = 0;
        logic [N+3:0] e;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid = (cyc < 16);
            a = N'(cyc + 1); b = 8'h01; bin = 1'b0;
            @(negedge clk);
            if (cyc < 16) begin
                n_tests++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_in_ready[%0d] got %b exp 1", cyc, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({diff, bout, ovf, zero, neg} !== e || diff !== N'(got)) begin
                    n_fail++;
                    $display("FAIL stream[%0d] got %h exp %h", got, {diff, bout, ovf, zero, neg}, e);
                end
                got++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
            @(posedge clk) #1;
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 16 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_count got %0d left %0d exp 16 left 0", got, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [N+3:0] snap, e;
        for (int cyc = 0; cyc < 16; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (cyc < 9);
            a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
            @(negedge clk);
            if (cyc >= 2 && cyc < 5) begin
                n_tests++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_stall[%0d] got in_ready=%b out_valid=%b exp 0 1", cyc, in_ready, out_valid);
                end
                if (cyc == 2) snap = {diff, bout, ovf, zero, neg};
                else begin
                    n_tests++;
                    if ({diff, bout, ovf, zero, neg} !== snap) begin
                        n_fail++;
                        $display("FAIL bp_hold[%0d] got %h exp %h", cyc, {diff, bout, ovf, zero, neg}, snap);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra got %h exp none", {diff, bout, ovf, zero, neg});
                end else begin
                    e = exp_q.pop_front();
                    if ({diff, bout, ovf, zero, neg} !== e) begin
                        n_fail++;
                        $display("FAIL bp_data got %h exp %h", {diff, bout, ovf, zero, neg}, e);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
            @(posedge clk) #1;
        end
        in_valid = 1'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain got %0d left exp 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h33; b = 8'h11; bin = 1'b0;
        @(posedge clk) #1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, diff, bout, ovf, zero, neg} !== '0) begin
            n_fail++;
            $display("FAIL reset_async got %h exp 0", {out_valid, diff, bout, ovf, zero, neg});
        end
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ghost[%0d] got out_valid=%b exp 0", cyc, out_valid);
            end
        end
        @(posedge clk) #1;
    endtask

    task automatic test_random();
        int sent = 0, cycles = 0;
        logic [N+3:0] e;
        while ((sent < 10000 || exp_q.size() != 0) && cycles < 60000) begin
            in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra got %h exp none", {diff, bout, ovf, zero, neg});
                end else begin
                    e = exp_q.pop_front();
                    if ({diff, bout, ovf, zero, neg} !== e) begin
                        n_fail++;
                        $display("FAIL rand_data got %h exp %h", {diff, bout, ovf, zero, neg}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, bin));
                sent++;
            end
            @(posedge clk) #1;
            cycles++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (sent != 10000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_timeout got sent=%0d left=%0d exp 10000 0", sent, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
        #12;
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
